mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single backing-memory port between the instruction-cache refill path (burst reads) and the data-memory path (single-word reads/writes). Sits between the datapath's icache/data-memory interfaces and the memory model. It sequences each transaction through a small FSM with registered memory-side outputs. Data requests have priority, and a starvation guard bounds instruction-side waiting.

## Interface
- `XLEN`, 32, data/address width
- `LINE_WORDS`, 4, words per icache refill burst; power of two, ≥2
- `STARVE_LIMIT`, 4, consecutive D grants allowed while I waits; 1..15

- `clk`  in  1  clock; reset reset, asynchronous, active-high; clock clk
- `reset`  in  1  asynchronous, active-high
- `i_req`  in  1  refill request; held until `i_done`
- `i_addr`  in  XLEN  refill byte address; low `log2(LINE_WORDS)+2` bits ignored
- `i_rvalid`  out  1  refill beat valid
- `i_rdata`  out  XLEN  refill beat data
- `i_done`  out  1  last refill beat
- `d_req`  in  1  data request; held until `d_done`
- `d_we`  in  1  1 = write
- `d_addr`  in  XLEN  word byte address
- `d_wdata`  in  XLEN  write data
- `d_wstrb`  in  4  byte enables
- `d_rdata`  out  XLEN  read data
- `d_done`  out  1  transaction complete
- `mem_req`, `mem_we`  out  1  memory request / write
- `mem_addr`, `mem_wdata`  out  XLEN  memory address / write data
- `mem_wstrb`  out  4  memory byte enables
- `mem_ack`  in  1  beat accepted/completed
- `mem_rdata`  in  XLEN  read data, valid with `mem_ack`
- `busy`  out  1  FSM not IDLE

## Operation
- FSM states IDLE, I_BUSY, D_BUSY.
- In IDLE, requests are sampled and a grant is decided:
  - Only `d_req` → D_BUSY.
  - Only `i_req` → I_BUSY.
  - Both, and `starve_cnt < STARVE_LIMIT` → D_BUSY.
  - Both, and `starve_cnt == STARVE_LIMIT` → I_BUSY.
- On grant, the winner's addr/we/wdata/wstrb are latched into the `mem_*` registers and `mem_req` is set to 1.
- I grants force `mem_we=0`, `mem_wstrb=0`, `mem_wdata=0`. D grants set `mem_wstrb=d_wstrb` for writes and 0 for reads.
- `starve_cnt` (4-bit):
  - +1 on a D grant with `i_req` high.
  - Cleared on any I grant.
  - Cleared on a D grant with `i_req` low.
  - Saturates at `STARVE_LIMIT`.
- I_BUSY:
  - `mem_addr = {i_addr[XLEN-1:OFF], beat, 2'b00}`, with `OFF = log2(LINE_WORDS)+2`.
  - `beat` starts at 0.
  - On `mem_ack` with `beat < LINE_WORDS-1`: `beat+1`, `mem_addr` updates next cycle, `mem_req` stays 1.
  - On `mem_ack` at the last beat → IDLE, `mem_req` cleared.
- D_BUSY: on `mem_ack` → IDLE, `mem_req` cleared.
- Combinational response outputs:
  - `i_rvalid = mem_ack & I_BUSY`, `i_rdata = mem_rdata`, `i_done = i_rvalid & beat==LINE_WORDS-1`.
  - `d_done = mem_ack & D_BUSY`, `d_rdata = mem_rdata`.
  - `i_rdata`/`d_rdata` are don't-care when not valid.
- `mem_ack` in IDLE is ignored.
- Requester inputs are not re-sampled mid-transaction.
- A requester must drop `req` the cycle after its done pulse. A `req` still high in IDLE is treated as a new request.

## Timing
- All outputs reset to 0; FSM to IDLE, `beat=0`, `starve_cnt=0`.
- Reset mid-transaction abandons it. `mem_req` deasserts asynchronously; no done pulse is issued.
- Request seen in IDLE at cycle N → `mem_req=1` at N+1.
- Zero-wait memory (`mem_ack` same cycle as `mem_req`):
  - D done at N+1.
  - I refill beats at N+1..N+LINE_WORDS.
- At least one IDLE cycle separates consecutive transactions.
- `mem_*` outputs stay stable while `mem_req=1` and `mem_ack=0`.
- `mem_addr` increments at most once per cycle and never crosses the line boundary (wraps within offset bits only).

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: starvation guard active as described.
- `MEM_ARB_STARVE_GUARD_EN` undefined:
  - `starve_cnt` is not implemented.
  - Strict D-over-I priority.
  - `STARVE_LIMIT` is ignored.

## Test plan
- Reset, then `d_req` read at 0x100 with `mem_ack` tied 1 and `mem_rdata=0xDEADBEEF` → `mem_req` high exactly one cycle with `mem_addr=0x100`; `d_done=1`, `d_rdata=0xDEADBEEF` the same cycle.
- `i_req` with `i_addr=0x20C`, LINE_WORDS=4, zero-wait → `mem_addr` 0x200, 0x204, 0x208, 0x20C on consecutive cycles; 4 `i_rvalid` pulses; `i_done` on the 4th only.
- `d_req` write (`wdata=0x12345678`, `wstrb=4'b0011`) with `mem_ack` delayed 3 cycles → `mem_*` stable for 4 cycles; one `d_done`.
- `i_req` and `d_req` held continuously, guard enabled, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I. With the macro undefined → I never granted.
- Assert `reset` during beat 2 of a refill → `mem_req`, `busy`, `i_rvalid` go 0 immediately. After release, a fresh `i_req` starts at beat 0.
- `mem_ack` pulsed while IDLE → no done pulses, no state change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory-port and status signals around the memory arbiter
interface mem_arbiter_if #(parameter int XLEN = 32);
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;
  logic            i_done;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [3:0]      d_wstrb;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            busy;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    output i_rvalid, i_rdata, i_done, d_rdata, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    input  i_rvalid, i_rdata, i_done, d_rdata, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache burst refills and data accesses; MEM_ARB_STARVE_GUARD_EN enables the I-side starvation guard
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int LINE_WORDS   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  state_t        state, state_n;
  logic [BW-1:0] beat;
  logic          grant_i, grant_d, last, starved;
  logic          unused_addr_bits;
  assign unused_addr_bits = ^bus.i_addr[OFF-1:0];
  assign last             = beat == BW'(LINE_WORDS - 1);
  assign bus.busy         = state != IDLE;
  assign bus.i_rvalid     = bus.mem_ack & (state == I_BUSY);
  assign bus.i_rdata      = bus.mem_rdata;
  assign bus.i_done       = bus.i_rvalid & last;
  assign bus.d_done       = bus.mem_ack & (state == D_BUSY);
  assign bus.d_rdata      = bus.mem_rdata;
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  assign starved = starve_cnt == 4'(STARVE_LIMIT);
  // count D grants taken while I waits; any I grant or an uncontested D grant clears it
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_cnt <= '0;
    else if (grant_i || (grant_d && !bus.i_req)) starve_cnt <= '0;
    else if (grant_d && !starved) starve_cnt <= starve_cnt + 4'd1;
`else
  localparam int unused_limit = STARVE_LIMIT;
  assign starved = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // grant decision in IDLE and transaction completion
  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state)
      IDLE: begin
        grant_d = bus.d_req & ~(bus.i_req & starved);
        grant_i = bus.i_req & ~grant_d;
        state_n = grant_d ? D_BUSY : grant_i ? I_BUSY : IDLE;
      end
      I_BUSY:  state_n = (bus.mem_ack && last) ? IDLE : I_BUSY;
      D_BUSY:  state_n = bus.mem_ack ? IDLE : D_BUSY;
      default: state_n = IDLE;
    endcase
  end
  // registered memory-side request; refill beats walk the address within the line
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      beat          <= '0;
    end else if (grant_d) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= bus.d_we;
      bus.mem_addr  <= bus.d_addr;
      bus.mem_wdata <= bus.d_wdata;
      bus.mem_wstrb <= bus.d_we ? bus.d_wstrb : 4'b0;
    end else if (grant_i) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {bus.i_addr[XLEN-1:OFF], {OFF{1'b0}}};
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      beat          <= '0;
    end else if (bus.mem_ack && state != IDLE) begin
      if (state == D_BUSY || last) begin
        bus.mem_req <= 1'b0;
        beat        <= '0;
      end else begin
        beat         <= beat + 1'b1;
        bus.mem_addr <= {bus.mem_addr[XLEN-1:OFF], BW'(beat + 1'b1), 2'b00};
      end
    end
endmodule
